// File: rtl/axis_loopback_pkg.sv
// rtl/axis_loopback_pkg.sv - mode and FSM state encodings shared by the loopback engine
package axis_loopback_pkg;

  typedef enum logic [1:0] {
    MODE_LOOP = 2'd0,
    MODE_INC  = 2'd1,
    MODE_GEN  = 2'd2,
    MODE_SINK = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    GEN  = 2'd2
  } state_e;

  // Number of set bits; callers zero-extend narrower keep vectors.
  function automatic logic [31:0] popcount32(input logic [31:0] v);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {31'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// rtl/axis_skid_buffer.sv - registered 2-entry skid buffer, ready output driven only by flops
module axis_skid_buffer #(
  parameter int DW = 32,
  parameter int KW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_tvalid_i,
  output logic          in_tready_o,
  input  logic [DW-1:0] in_tdata_i,
  input  logic [KW-1:0] in_tkeep_i,
  input  logic          in_tlast_i,
  output logic          out_tvalid_o,
  input  logic          out_tready_i,
  output logic [DW-1:0] out_tdata_o,
  output logic [KW-1:0] out_tkeep_o,
  output logic          out_tlast_o,
  output logic          skid_valid_o
);
  localparam int PW = DW + KW + 1;

  logic [PW-1:0] in_pl, out_pl_q, out_pl_d, skid_pl_q, skid_pl_d;
  logic          out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;

  assign in_pl        = {in_tlast_i, in_tkeep_i, in_tdata_i};
  assign in_tready_o  = ~skid_valid_q;
  assign out_tvalid_o = out_valid_q;
  assign {out_tlast_o, out_tkeep_o, out_tdata_o} = out_pl_q;
  assign skid_valid_o = skid_valid_q;

  // Output slot refills from the skid slot first; new beats park in the skid slot on a stall.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_pl_d     = out_pl_q;
    skid_valid_d = skid_valid_q;
    skid_pl_d    = skid_pl_q;
    if (skid_valid_q) begin
      if (out_tready_i) begin
        out_pl_d     = skid_pl_q;
        skid_valid_d = 1'b0;
      end
    end else if (in_tvalid_i) begin
      if (!out_valid_q || out_tready_i) begin
        out_valid_d = 1'b1;
        out_pl_d    = in_pl;
      end else begin
        skid_valid_d = 1'b1;
        skid_pl_d    = in_pl;
      end
    end else if (out_tready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // Both slots clear on reset so any in-flight beats are dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      out_pl_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_pl_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_pl_q     <= out_pl_d;
      skid_valid_q <= skid_valid_d;
      skid_pl_q    <= skid_pl_d;
    end
  end

endmodule

// File: rtl/axis_loopback_engine.sv
// rtl/axis_loopback_engine.sv - AXI-stream loop/increment/generate/sink engine; AXIS_LOOPBACK_STATS_EN enables counters
module axis_loopback_engine
  import axis_loopback_pkg::*;
#(
  parameter int  EW        = 2,
  parameter int  GEN_LEN_W = 16,
  localparam int DW        = 8 << EW,
  localparam int KW        = 1 << EW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic [GEN_LEN_W-1:0] gen_len,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic [DW-1:0]        s_tdata,
  input  logic [KW-1:0]        s_tkeep,
  input  logic                 s_tlast,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [DW-1:0]        m_tdata,
  output logic [KW-1:0]        m_tkeep,
  output logic                 m_tlast,
  output logic [7:0]           last_byte,
  output logic                 busy,
  output logic [31:0]          pkt_cnt,
  output logic [31:0]          byte_cnt
);
  state_e               state_q, state_d;
  mode_e                mode_q, mode_d, mode_in, eff_mode;
  logic [GEN_LEN_W-1:0] gen_idx_q, gen_idx_d, gen_end_q, gen_end_d;
  logic [7:0]           gen_byte_q, gen_byte_d, last_byte_q;
  logic                 gen_done_q, gen_done_d;
  logic                 rdy, s_acc, gen_push, gen_last, out_fire;
  logic                 sk_in_tvalid, sk_in_tready, sk_in_tlast, sk_skid_valid;
  logic [DW-1:0]        sk_in_tdata, inc_data, gen_data;
  logic [KW-1:0]        sk_in_tkeep;

  // The mode input only steers the engine while IDLE; afterwards the latched copy rules.
  assign mode_in   = mode_e'(mode);
  assign eff_mode  = (state_q == IDLE) ? mode_in : mode_q;
  assign busy      = (state_q != IDLE);
  assign last_byte = last_byte_q;
  assign out_fire  = m_tvalid & m_tready;
  assign gen_last  = (gen_idx_q == gen_end_q);
  assign gen_push  = (state_q == GEN) & sk_in_tvalid & sk_in_tready;

  // Input ready: SINK always drains, GEN blocks, LOOP/INC follow skid-buffer space.
  always_comb begin
    rdy = 1'b0;
    if (state_q != GEN) begin
      case (eff_mode)
        MODE_SINK: rdy = 1'b1;
        MODE_GEN:  rdy = 1'b0;
        default:   rdy = sk_in_tready;
      endcase
    end
  end
  assign s_tready = rdy & ~rst;
  assign s_acc    = s_tvalid & s_tready;

  // Byte-lane transforms: +1 on kept lanes for INC, counting pattern for GEN.
  always_comb begin
    inc_data = s_tdata;
    gen_data = '0;
    for (int j = 0; j < KW; j++) begin
      if (s_tkeep[j]) inc_data[8*j +: 8] = s_tdata[8*j +: 8] + 8'd1;
      gen_data[8*j +: 8] = gen_byte_q + 8'(j);
    end
  end

  // Select what enters the skid buffer: generated words in GEN, accepted beats in LOOP/INC.
  always_comb begin
    sk_in_tvalid = 1'b0;
    sk_in_tdata  = s_tdata;
    sk_in_tkeep  = s_tkeep;
    sk_in_tlast  = s_tlast;
    if (state_q == GEN) begin
      sk_in_tvalid = ~gen_done_q;
      sk_in_tdata  = gen_data;
      sk_in_tkeep  = '1;
      sk_in_tlast  = gen_last;
    end else if (eff_mode == MODE_LOOP || eff_mode == MODE_INC) begin
      sk_in_tvalid = s_acc;
      if (eff_mode == MODE_INC) sk_in_tdata = inc_data;
    end
  end

  // Next-state logic; GEN ends only once its own tlast word is the beat leaving the buffer.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    gen_idx_d  = gen_idx_q;
    gen_end_d  = gen_end_q;
    gen_byte_d = gen_byte_q;
    gen_done_d = gen_done_q;
    case (state_q)
      IDLE: begin
        mode_d = mode_in;
        if (mode_in == MODE_GEN) begin
          state_d    = GEN;
          gen_idx_d  = '0;
          gen_byte_d = '0;
          gen_done_d = 1'b0;
          gen_end_d  = (gen_len == '0) ? '0 : gen_len - GEN_LEN_W'(1);
        end else if (s_acc && !s_tlast) begin
          state_d = PASS;
        end
      end
      PASS: if (s_acc && s_tlast) state_d = IDLE;
      GEN: begin
        if (gen_push) begin
          if (gen_last) begin
            gen_done_d = 1'b1;
          end else begin
            gen_idx_d  = gen_idx_q + GEN_LEN_W'(1);
            gen_byte_d = gen_byte_q + 8'(KW);
          end
        end
        if (gen_done_q && out_fire && m_tlast && !sk_skid_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched mode, generator and last-byte registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= MODE_LOOP;
      gen_idx_q   <= '0;
      gen_end_q   <= '0;
      gen_byte_q  <= '0;
      gen_done_q  <= 1'b0;
      last_byte_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      gen_idx_q  <= gen_idx_d;
      gen_end_q  <= gen_end_d;
      gen_byte_q <= gen_byte_d;
      gen_done_q <= gen_done_d;
      if (s_acc) last_byte_q <= s_tdata[7:0];
    end
  end

  axis_skid_buffer #(.DW(DW), .KW(KW)) u_skid (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_tvalid_i  (sk_in_tvalid),
    .in_tready_o  (sk_in_tready),
    .in_tdata_i   (sk_in_tdata),
    .in_tkeep_i   (sk_in_tkeep),
    .in_tlast_i   (sk_in_tlast),
    .out_tvalid_o (m_tvalid),
    .out_tready_i (m_tready),
    .out_tdata_o  (m_tdata),
    .out_tkeep_o  (m_tkeep),
    .out_tlast_o  (m_tlast),
    .skid_valid_o (sk_skid_valid)
  );

`ifdef AXIS_LOOPBACK_STATS_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d, byte_cnt_q, byte_cnt_d;
  logic        sink_fire;

  assign sink_fire = s_acc & (state_q != GEN) & (eff_mode == MODE_SINK);

  // Count delivered output beats plus beats swallowed in SINK; both wrap naturally.
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    byte_cnt_d = byte_cnt_q;
    if (out_fire) begin
      pkt_cnt_d  = pkt_cnt_d + {31'd0, m_tlast};
      byte_cnt_d = byte_cnt_d + popcount32(32'(m_tkeep));
    end
    if (sink_fire) begin
      pkt_cnt_d  = pkt_cnt_d + {31'd0, s_tlast};
      byte_cnt_d = byte_cnt_d + popcount32(32'(s_tkeep));
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_q  <= '0;
      byte_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign byte_cnt = byte_cnt_q;
`else
  assign pkt_cnt  = '0;
  assign byte_cnt = '0;
`endif

endmodule

// File: tb/tb_axis_loopback_engine.sv
// tb/tb_axis_loopback_engine.sv - directed self-checking bench for axis_loopback_engine
`timescale 1ns/1ps
module tb_axis_loopback_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [15:0] gen_len;
  logic        s_tvalid, s_tready, s_tlast;
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic        m_tvalid, m_tready, m_tlast;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic [7:0]  last_byte;
  logic        busy;
  logic [31:0] pkt_cnt, byte_cnt;

  int          vecs = 0;
  int          errs = 0;
  logic [36:0] outq[$];
  logic        toggle_en = 1'b0;
  int          stall_run = 0;
  int          max_stall = 0;
  logic        prev_stall = 1'b0;
  logic [36:0] prev_pl = '0;

  always #5 clk = ~clk;

  axis_loopback_engine #(.EW(2), .GEN_LEN_W(16)) dut (
    .clk(clk), .rst(rst), .mode(mode), .gen_len(gen_len),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .last_byte(last_byte), .busy(busy), .pkt_cnt(pkt_cnt), .byte_cnt(byte_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_en) m_tready = ~m_tready;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    logic ok;
    ok = 1'b0;
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l;
    for (int c = 0; c < 40; c++) begin
      #1;
      ok = s_tready;
      tick();
      if (ok) break;
    end
    chk("send_accept", ok, 1);
  endtask

  task automatic drain(input string tag);
    int c;
    c = 0;
    while ((busy || m_tvalid) && c < 100) begin
      tick();
      c++;
    end
    chk(tag, busy || m_tvalid, 0);
  endtask

  // Output monitor: captures delivered beats, checks payload hold under back-pressure, tracks input stalls.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      stall_run  = 0;
    end else begin
      if (prev_stall) chk("hold_payload", {m_tvalid, m_tlast, m_tkeep, m_tdata}, {1'b1, prev_pl});
      if (m_tvalid && m_tready) outq.push_back({m_tlast, m_tkeep, m_tdata});
      prev_stall = m_tvalid && !m_tready;
      prev_pl    = {m_tlast, m_tkeep, m_tdata};
      if (toggle_en && s_tvalid && !s_tready) stall_run++;
      else stall_run = 0;
      if (stall_run > max_stall) max_stall = stall_run;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    logic [31:0] d;
    rst = 1'b1; mode = 2'd3; gen_len = '0;
    s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_payload", {m_tlast, m_tkeep, m_tdata}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_last_byte", last_byte, 0);
    chk("rst_counters", {pkt_cnt, byte_cnt}, 0);
    mode = 2'd0;
    rst  = 1'b0;
    #1;
    chk("post_rst_s_tready", s_tready, 1);
    tick();

    // LOOP: three beats, one cycle latency each
    send_beat(32'h03020100, 4'hF, 1'b0);
    chk("loop_b0", {m_tvalid, m_tlast, m_tkeep, m_tdata}, {1'b1, 1'b0, 4'hF, 32'h03020100});
    chk("loop_busy_mid", busy, 1);
    send_beat(32'h07060504, 4'hF, 1'b0);
    chk("loop_b1", {m_tvalid, m_tlast, m_tkeep, m_tdata}, {1'b1, 1'b0, 4'hF, 32'h07060504});
    send_beat(32'h0B0A0908, 4'hF, 1'b1);
    s_tvalid = 1'b0;
    chk("loop_b2", {m_tvalid, m_tlast, m_tkeep, m_tdata}, {1'b1, 1'b1, 4'hF, 32'h0B0A0908});
    chk("loop_last_byte", last_byte, 8'h08);
    chk("loop_busy_end", busy, 0);
    tick();
    chk("loop_idle_out", m_tvalid, 0);

    // LOOP: beat with no kept bytes is still forwarded
    send_beat(32'hDEADBEEF, 4'h0, 1'b1);
    s_tvalid = 1'b0;
    chk("loop_keep0", {m_tvalid, m_tlast, m_tkeep, m_tdata}, {1'b1, 1'b1, 4'h0, 32'hDEADBEEF});
    chk("loop_keep0_last_byte", last_byte, 8'hEF);
    tick();

    // INC: only kept lanes increment
    mode = 2'd1;
    send_beat(32'h12FF3400, 4'b0111, 1'b1);
    s_tvalid = 1'b0;
    chk("inc_beat", {m_tvalid, m_tlast, m_tkeep, m_tdata}, {1'b1, 1'b1, 4'b0111, 32'h12003501});
    chk("inc_last_byte", last_byte, 8'h00);
    tick();

    // GEN, gen_len=2, repeated while mode stays 2
    outq.delete();
    mode = 2'd2; gen_len = 16'd2;
    tick(); tick();
    chk("gen_busy", busy, 1);
    chk("gen_s_tready", s_tready, 0);
    repeat (16) tick();
    mode = 2'd0;
    drain("gen2_drain");
    chk("gen2_even", outq.size() % 2, 0);
    chk("gen2_enough", outq.size() >= 4, 1);
    foreach (outq[i])
      chk("gen2_word", outq[i], (i % 2 == 0) ? {1'b0, 4'hF, 32'h03020100} : {1'b1, 4'hF, 32'h07060504});

    // GEN, gen_len=0 behaves as single-word packets
    outq.delete();
    mode = 2'd2; gen_len = 16'd0;
    repeat (10) tick();
    mode = 2'd0;
    drain("gen0_drain");
    chk("gen0_enough", outq.size() >= 2, 1);
    foreach (outq[i]) chk("gen0_word", outq[i], {1'b1, 4'hF, 32'h03020100});

    // LOOP at full rate with m_tready toggling
    outq.delete();
    max_stall = 0;
    m_tready  = 1'b1;
    toggle_en = 1'b1;
    for (int i = 0; i < 8; i++) send_beat(32'h10203040 + 32'(i), 4'hF, i == 7);
    s_tvalid = 1'b0;
    drain("tog_drain");
    toggle_en = 1'b0;
    m_tready  = 1'b1;
    chk("tog_count", outq.size(), 8);
    for (int i = 0; i < 8 && i < outq.size(); i++) begin
      d = 32'h10203040 + 32'(i);
      chk("tog_beat", outq[i], {(i == 7), 4'hF, d});
    end
    chk("tog_max_stall", max_stall <= 1, 1);

    // LOOP -> SINK switch mid-packet
    outq.delete();
    mode = 2'd0;
    tick();
    send_beat(32'h000000C1, 4'hF, 1'b0);
    mode = 2'd3;
    send_beat(32'h000000C2, 4'hF, 1'b0);
    send_beat(32'h000000C3, 4'hF, 1'b1);
    s_tvalid = 1'b0;
    tick(); tick();
    chk("sw_fwd_count", outq.size(), 3);
    chk("sw_fwd_last", outq[2], {1'b1, 4'hF, 32'h000000C3});
    m_tready = 1'b0;
    s_tvalid = 1'b1; s_tdata = 32'h000000B4; s_tkeep = 4'hF; s_tlast = 1'b0;
    #1;
    chk("sink_s_tready", s_tready, 1);
    send_beat(32'h000000B4, 4'hF, 1'b0);
    chk("sink_busy_mid", busy, 1);
    send_beat(32'h000000A5, 4'h3, 1'b1);
    s_tvalid = 1'b0;
    chk("sink_m_tvalid", m_tvalid, 0);
    chk("sink_busy_end", busy, 0);
    chk("sink_last_byte", last_byte, 8'hA5);
    tick();
    chk("sink_no_out", outq.size(), 3);

    // Reset during GEN word 1 of 4
    m_tready = 1'b1;
    outq.delete();
    gen_len = 16'd4; mode = 2'd2;
    wc = 0;
    while (!(m_tvalid && m_tdata == 32'h07060504) && wc < 30) begin
      tick();
      wc++;
    end
    chk("gen4_w1_seen", {m_tvalid, m_tdata}, {1'b1, 32'h07060504});
    rst = 1'b1;
    #1;
    chk("rst_mid_out", {m_tvalid, m_tlast, m_tkeep, m_tdata}, 0);
    chk("rst_mid_ctl", {s_tready, busy, last_byte}, 0);
    chk("rst_mid_cnt", {pkt_cnt, byte_cnt}, 0);
    mode = 2'd0;
    tick(); tick();
    rst = 1'b0;
    outq.delete();
    #1;
    chk("rel_fresh", {busy, m_tvalid, s_tready}, 3'b001);
    tick();
    send_beat(32'h0000005A, 4'hF, 1'b1);
    s_tvalid = 1'b0;
    tick(); tick();
    chk("rel_count", outq.size(), 1);
    chk("rel_beat", outq[0], {1'b1, 4'hF, 32'h0000005A});
`ifdef AXIS_LOOPBACK_STATS_EN
    chk("stats_pkt", pkt_cnt, 1);
    chk("stats_bytes", byte_cnt, 4);
`else
    chk("stats_tied", {pkt_cnt, byte_cnt}, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
